// File: rtl/windowed_majority_detector.sv
// Sliding-window threshold detector: counts ones among the last WINDOW accepted
// samples and raises a registered decision plus a one-cycle rising-edge event.
module windowed_majority_detector #(
  parameter int WINDOW = 5,
  parameter int THRESH = 3,
  parameter int CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_val,
  input  logic          in_bit,
  input  logic          clear,
  output logic          out_val,
  output logic          out,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          rise
);

  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
  localparam logic [CW-1:0] THR_C = CW'(THRESH);

  logic [WINDOW-1:0] win_p0;
  logic [CW-1:0]     fill_p0;
  logic [CW-1:0]     cnt_p0;
  logic              vld_p0;
  logic              out_p0;
  logic              rise_p0;

  logic [CW-1:0]     fill_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              vld_nxt;
  logic              out_nxt;

  // Next-state values assuming the current cycle accepts a sample.
  // Once full, the oldest bit leaves as the new one enters, so the count
  // moves by at most one and stays within 0..WINDOW.
  always_comb begin
    fill_nxt = fill_p0;
    cnt_nxt  = cnt_p0;
    if (fill_p0 != WIN_C) begin
      fill_nxt = fill_p0 + CW'(1);
      cnt_nxt  = cnt_p0 + CW'(in_bit);
    end else begin
      cnt_nxt  = cnt_p0 + CW'(in_bit) - CW'(win_p0[WINDOW-1]);
    end
    vld_nxt = (fill_nxt == WIN_C);
    out_nxt = vld_nxt & (cnt_nxt >= THR_C);
  end

  // Stage p0: window, counters and registered decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p0  <= '0;
      fill_p0 <= '0;
      cnt_p0  <= '0;
      vld_p0  <= 1'b0;
      out_p0  <= 1'b0;
      rise_p0 <= 1'b0;
    end else if (clear) begin
      win_p0  <= '0;
      fill_p0 <= '0;
      cnt_p0  <= '0;
      vld_p0  <= 1'b0;
      out_p0  <= 1'b0;
      rise_p0 <= 1'b0;
    end else if (in_val) begin
      win_p0  <= {win_p0[WINDOW-2:0], in_bit};
      fill_p0 <= fill_nxt;
      cnt_p0  <= cnt_nxt;
      vld_p0  <= vld_nxt;
      out_p0  <= out_nxt;
      rise_p0 <= out_nxt & ~out_p0;
    end else begin
      rise_p0 <= 1'b0;
    end
  end

  assign out_val = vld_p0;
  assign full    = vld_p0;
  assign out     = out_p0;
  assign count   = cnt_p0;
  assign rise    = rise_p0;

endmodule

// File: tb/tb_windowed_majority_detector.sv
// Directed bench for windowed_majority_detector: a 5/3 instance for fill, slide,
// gaps, clear and reset, and a 3/2 instance for majority equivalence.
module tb_windowed_majority_detector;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_in_val, a_in_bit, a_clear;
  logic       a_out_val, a_out, a_full, a_rise;
  logic [2:0] a_count;

  logic       b_in_val, b_in_bit, b_clear;
  logic       b_out_val, b_out, b_full, b_rise;
  logic [1:0] b_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  windowed_majority_detector #(.WINDOW(5), .THRESH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_val(a_in_val), .in_bit(a_in_bit), .clear(a_clear),
    .out_val(a_out_val), .out(a_out), .count(a_count), .full(a_full), .rise(a_rise)
  );

  windowed_majority_detector #(.WINDOW(3), .THRESH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_val(b_in_val), .in_bit(b_in_bit), .clear(b_clear),
    .out_val(b_out_val), .out(b_out), .count(b_count), .full(b_full), .rise(b_rise)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check every output of instance A at once.
  task automatic check_a(input string tag, input int cnt, input int ov, input int o, input int r);
    check({tag, ".count"},   int'(a_count),   cnt);
    check({tag, ".out_val"}, int'(a_out_val), ov);
    check({tag, ".full"},    int'(a_full),    ov);
    check({tag, ".out"},     int'(a_out),     o);
    check({tag, ".rise"},    int'(a_rise),    r);
  endtask

  task automatic push_a(input logic b);
    a_in_val = 1'b1;
    a_in_bit = b;
    @(posedge clk); #1;
    a_in_val = 1'b0;
  endtask

  task automatic push_b(input logic b);
    b_in_val = 1'b1;
    b_in_bit = b;
    @(posedge clk); #1;
    b_in_val = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [2:0] hist;
  int         exp_maj;

  initial begin
    rst_n = 1'b0;
    a_in_val = 1'b0; a_in_bit = 1'b0; a_clear = 1'b0;
    b_in_val = 1'b0; b_in_bit = 1'b0; b_clear = 1'b0;
    idle(3);
    check_a("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    // Fill 1,1,1,0,0
    push_a(1'b1); check_a("fill1", 1, 0, 0, 0);
    push_a(1'b1); check_a("fill2", 2, 0, 0, 0);
    push_a(1'b1); check_a("fill3", 3, 0, 0, 0);
    push_a(1'b0); check_a("fill4", 3, 0, 0, 0);
    push_a(1'b0); check_a("fill5", 3, 1, 1, 1);
    idle(1);      check_a("fill5_hold", 3, 1, 1, 0);

    // Slide: window after each push (oldest..newest)
    push_a(1'b0); check_a("slide0", 2, 1, 0, 0);   // 1,1,0,0,0
    push_a(1'b1); check_a("slide1", 2, 1, 0, 0);   // 1,0,0,0,1
    push_a(1'b1); check_a("slide2", 2, 1, 0, 0);   // 0,0,0,1,1
    push_a(1'b1); check_a("slide3", 3, 1, 1, 1);   // 0,0,1,1,1

    // Gaps: nothing moves, rise drops and stays low
    for (int i = 0; i < 7; i++) begin
      idle(1);
      check_a("gap", 3, 1, 1, 0);
    end
    push_a(1'b1); check_a("after_gap", 4, 1, 1, 0); // 0,1,1,1,1

    // Clear collides with a valid sample; the sample is dropped
    a_clear = 1'b1; a_in_val = 1'b1; a_in_bit = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0; a_in_val = 1'b0;
    check_a("clear", 0, 0, 0, 0);
    push_a(1'b1); check_a("refill1", 1, 0, 0, 0);
    push_a(1'b1); check_a("refill2", 2, 0, 0, 0);
    push_a(1'b1); check_a("refill3", 3, 0, 0, 0);
    push_a(1'b1); check_a("refill4", 4, 0, 0, 0);
    push_a(1'b1); check_a("refill5", 5, 1, 1, 1);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    check_a("rst_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);
    push_a(1'b1); check_a("post_rst1", 1, 0, 0, 0);
    push_a(1'b1); check_a("post_rst2", 2, 0, 0, 0);
    push_a(1'b1); check_a("post_rst3", 3, 0, 0, 0);
    push_a(1'b1); check_a("post_rst4", 4, 0, 0, 0);
    push_a(1'b1); check_a("post_rst5", 5, 1, 1, 1);

    // Majority equivalence on the 3/2 instance
    push_b(1'b0); check("b_fill1.out_val", int'(b_out_val), 0);
    push_b(1'b0); check("b_fill2.out_val", int'(b_out_val), 0);
    push_b(1'b0);
    check("b_fill3.out_val", int'(b_out_val), 1);
    check("b_fill3.out",     int'(b_out),     0);
    check("b_fill3.count",   int'(b_count),   0);
    hist = 3'b000;
    for (int p = 0; p < 8; p++) begin
      for (int k = 2; k >= 0; k--) begin
        logic bit_v;
        bit_v = p[k];
        hist = {hist[1:0], bit_v};
        push_b(bit_v);
        exp_maj = int'((hist[2] & hist[1]) | (hist[0] & (hist[2] | hist[1])));
        check($sformatf("maj_p%0d_k%0d", p, k), int'(b_out), exp_maj);
      end
      check($sformatf("maj_p%0d.count", p), int'(b_count), $countones(p[2:0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
